fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit.
- Holds the PC and issues single-outstanding word reads to instruction memory over a req/ready + rvalid handshake.
- Latches the returned instruction and presents it, with decoded fields (opcode, funct3, funct7, register indices), to control/decode until the downstream stage retires it.
- Computes the next PC as sequential (+4) or branch redirect from the execute/branch logic.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  read request valid.
- imem_addr  out  XLEN  word-aligned read address (equals pc).
- imem_ready  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  instr and fields valid.
- instr_ready  in  1  downstream retires current instruction.
- instr  out  32  latched instruction.
- pc  out  XLEN  address of current/requested instruction.
- opcode  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- funct7  out  7  instr[31:25].
- rd, rs1, rs2  out  5 each  instr[11:7], instr[19:15], instr[24:20].
- branch_taken  in  1  redirect request, sampled only at retire.
- branch_target  in  XLEN  redirect address.
- misalign_err  out  1  one-cycle pulse: branch_target[1:0] != 0 at retire.

Behaviour:
- Reset: async assert on rst_n low.
  - State FETCH, pc=RESET_PC, instr=32'h0000_0013 (NOP).
  - instr_valid=0, misalign_err=0, flush flag=0.
  - imem_req=0 while rst_n low; may assert the first cycle after release.
- FSM states: FETCH, WAIT, HOLD.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ready → WAIT; otherwise stay, with addr held stable.
  - WAIT: imem_req=0. On imem_rvalid: instr<=imem_rdata, instr_valid<=1 next cycle → HOLD.
  - HOLD: instr_valid=1, outputs stable. On instr_ready: pc <= branch_taken ? {branch_target[XLEN-1:2],2'b00} : pc+4; instr_valid<=0; → FETCH.
- Latency: FETCH-to-HOLD is a minimum of 2 cycles (ready in cycle 0, rvalid in cycle 1, instr_valid in cycle 2).
- Throughput: at most 1 instruction per 3 cycles. No prefetch; single outstanding request.
- Decoded fields are pure slices of the instr register. They are registered and glitch-free, and valid only while instr_valid=1.
- branch_taken/branch_target are ignored unless instr_valid && instr_ready in the same cycle.
- misalign_err pulses for 1 cycle when a taken branch has target[1:0]!=0. The PC is force-aligned; there is no trap.
- PC arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC + 4 → 32'h0000_0000, with no flag.
- imem_rvalid in FETCH or HOLD (spurious, or stale from before reset) is ignored and the data discarded.
- imem_rdata is captured only on rvalid in WAIT.
- Reset mid-WAIT: the response arriving after reset is discarded (state is FETCH). The fetch restarts at RESET_PC.
- instr_ready while instr_valid=0 has no effect.

Decomposition:
- Shared defines file (existing): OPCODE_* constants, NOP encoding 32'h0000_0013, FETCH/WAIT/HOLD state encodings (2 bits), RESET_PC default, and field bit positions for opcode/funct3/funct7/rd/rs1/rs2.
- Optional sub-module pc_gen: combinational next-PC mux (pc+4 vs aligned target) plus misalign detect.
- All state lives in fetch_unit.

Test Plan:
- Reset/first fetch: hold rst_n=0 5 cycles, release; memory ready=1, rvalid next cycle with 32'h00500093 → imem_addr=0; instr_valid=1 two cycles after req; opcode=7'h13, rd=1, funct3=0.
- Sequential stream: respond to 0x0,0x4,0x8 with ADD x3,x1,x2 (32'h002081B3); hold instr_ready=1 → pc sequence 0,4,8; funct7=0, opcode=7'h33, rs1=1, rs2=2.
- Backpressure: instr_ready=0 for 4 cycles in HOLD → instr and pc stable, imem_req=0, no new fetch; ready=1 → next req at pc+4.
- Branch redirect: at pc=0x10 retire BEQ (32'h00208463) with branch_taken=1, target=0x18 → next imem_addr=0x18; branch_taken=1 without instr_ready → ignored, next addr unchanged.
- Misaligned target and wrap: target 0x22 → misalign_err one-cycle pulse, next addr 0x20; pc=0xFFFFFFFC retired with no branch → next addr 0x0.
- Memory stall and reset mid-op: imem_ready=0 for 3 cycles → req/addr held stable. Assert rst_n low during WAIT, then deliver rvalid with 32'hDEADBEEF after release → data discarded, instr stays NOP, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: state encoding, NOP, reset PC and RV32 field positions.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OPCODE_LOAD   = 7'h03;
  localparam logic [6:0] OPCODE_OP_IMM = 7'h13;
  localparam logic [6:0] OPCODE_AUIPC  = 7'h17;
  localparam logic [6:0] OPCODE_STORE  = 7'h23;
  localparam logic [6:0] OPCODE_OP     = 7'h33;
  localparam logic [6:0] OPCODE_LUI    = 7'h37;
  localparam logic [6:0] OPCODE_BRANCH = 7'h63;
  localparam logic [6:0] OPCODE_JALR   = 7'h67;
  localparam logic [6:0] OPCODE_JAL    = 7'h6f;

  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned OPCODE_MSB = 6;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned RD_MSB     = 11;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned FUNCT3_MSB = 14;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS1_MSB    = 19;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned RS2_MSB    = 24;
  localparam int unsigned FUNCT7_LSB = 25;
  localparam int unsigned FUNCT7_MSB = 31;

endpackage

// File: rtl/fetch_unit_pc_gen.sv
// Next-PC selection: sequential +4 (wrapping) or word-aligned branch target,
// with detection of a misaligned taken target.
module fetch_unit_pc_gen #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign
);

  always_comb begin
    next_pc  = pc + XLEN'(4);
    misalign = 1'b0;
    if (branch_taken) begin
      next_pc  = {branch_target[XLEN-1:2], 2'b00};
      misalign = |branch_target[1:0];
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem reads, instruction latch
// with decoded fields, and PC advance/redirect on retire.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            misalign_err
);

  fetch_state_t    state;
  logic [XLEN-1:0] next_pc;
  logic            misalign;

  fetch_unit_pc_gen #(.XLEN(XLEN)) u_pc_gen (
    .pc            (pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .next_pc       (next_pc),
    .misalign      (misalign)
  );

  // imem_req is registered so it stays low throughout reset; a handshake in
  // FETCH only counts once the request is actually visible on the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      instr        <= NOP_INSTR;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
      imem_req     <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      case (state)
        FETCH: begin
          imem_req <= 1'b1;
          if (imem_req && imem_ready) begin
            imem_req <= 1'b0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            pc           <= next_pc;
            misalign_err <= misalign;
            instr_valid  <= 1'b0;
            imem_req     <= 1'b1;
            state        <= FETCH;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= FETCH;
        end
      endcase
    end
  end

  assign imem_addr = pc;
  assign opcode    = instr[OPCODE_MSB:OPCODE_LSB];
  assign rd        = instr[RD_MSB:RD_LSB];
  assign funct3    = instr[FUNCT3_MSB:FUNCT3_LSB];
  assign rs1       = instr[RS1_MSB:RS1_LSB];
  assign rs2       = instr[RS2_MSB:RS2_LSB];
  assign funct7    = instr[FUNCT7_MSB:FUNCT7_LSB];

endmodule
